itcm_loader: RTL

ITCM_LOADER -- requirements
Module: itcm_loader

---
 rtl/itcm_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/itcm_loader.sv
// Boot-time ITCM loader: parses a little-endian byte stream (word count + words) and writes words to the ITCM.
// Optional trailing 32-bit checksum check is enabled by defining LOADER_CHECKSUM_EN.
module itcm_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t                r_state;
  logic [1:0]            r_bcnt;
  logic [23:0]           r_shift;
  logic [31:0]           r_count;
  logic [31:0]           r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]           r_sum;
`endif

  logic        w_accept;
  logic        w_word_end;
  logic [31:0] w_word;

  // The incoming byte lands in the top of the word, so the first byte ends up in bits 7:0.
  assign w_accept   = s_valid & r_ready;
  assign w_word_end = w_accept & (r_bcnt == 2'd3);
  assign w_word     = {s_data, r_shift};

  assign s_ready  = r_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_hold;
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bcnt    <= 2'd0;
      r_shift   <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        r_bcnt  <= r_bcnt + 2'd1;
        r_shift <= w_word[31:8];
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state <= S_HDR;
            r_bcnt  <= 2'd0;
            r_idx   <= '0;
            r_addr  <= BASE_ADDR;
            r_ready <= 1'b1;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        S_HDR: begin
          if (w_word_end) begin
            r_count <= w_word;
            if ((w_word == 32'd0) || (w_word > 32'(MAX_WORDS))) begin
              r_state <= S_ERR;
              r_ready <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_end) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= DATA_WIDTH'(w_word);
            r_addr    <= r_addr + ADDR_WIDTH'(4);
            r_idx     <= r_idx + 32'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= r_sum + w_word;
            if (r_idx == r_count - 32'd1) r_state <= S_CSUM;
`else
            if (r_idx == r_count - 32'd1) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          // Written words stay in the ITCM on mismatch; only the status reflects the failure.
          if (w_word_end) begin
            r_ready <= 1'b0;
            if (w_word == r_sum) begin
              r_state <= S_DONE;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

endmodule
